// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a shared single-port memory
// with a fixed access latency of WAIT_CYCLES cycles. Each access runs IDLE -> ACCESS -> DONE.
module mem_arbiter #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Wide enough for the largest legal latency (15).
    localparam int unsigned   CW        = 4;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          last_q;  // 1: port 1 was the most recent grant
    logic          we_q;

    logic          pick1;
    logic          pick_we;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;

    // Select the winner: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
            pick1 = ~last_q;
        end
        pick_we    = pick1 ? we1    : we0;
        pick_addr  = pick1 ? addr1  : addr0;
        pick_wdata = pick1 ? wdata1 : wdata0;
    end

    // Access sequencer; every output is registered here so all are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_we    <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_we <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        state_q   <= StAccess;
                        cnt_q     <= WAIT_LOAD;
                        last_q    <= pick1;
                        we_q      <= pick_we;
                        grant     <= pick1 ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        mem_addr  <= pick_addr;
                        mem_wdata <= pick_wdata;
                        // With a one-cycle latency the first access cycle is also the last.
                        mem_we    <= pick_we && (WAIT_LOAD == CW'(1));
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StDone;
                        ack0    <= grant[0];
                        ack1    <= grant[1];
                        if (!we_q) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        // Raise the strobe so it is high during the final access cycle only.
                        mem_we <= we_q && (cnt_q == CW'(2));
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives three arbiters (latency 2, 1, 15) from shared inputs and checks them
// against a transaction-timeline model, a directed vector table and hand-written sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;

    logic        ack0_a [3];
    logic        ack1_a [3];
    logic        busy_a [3];
    logic        mwe_a  [3];
    logic [1:0]  grant_a [3];
    logic [31:0] rdata_a [3];
    logic [31:0] maddr_a [3];
    logic [31:0] mwd_a   [3];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned WC = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
        mem_arbiter #(.DW(32), .AW(32), .WAIT_CYCLES(WC)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req0      (req0),
            .req1      (req1),
            .we0       (we0),
            .we1       (we1),
            .addr0     (addr0),
            .addr1     (addr1),
            .wdata0    (wdata0),
            .wdata1    (wdata1),
            .ack0      (ack0_a[k]),
            .ack1      (ack1_a[k]),
            .rdata     (rdata_a[k]),
            .grant     (grant_a[k]),
            .busy      (busy_a[k]),
            .mem_addr  (maddr_a[k]),
            .mem_we    (mwe_a[k]),
            .mem_wdata (mwd_a[k]),
            .mem_rdata (mem_rdata)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time. A grant at edge g yields access cycles
    // g..g+W-1 (write strobe in the last), ack after edge g+W, idle again after edge g+W+1.
    logic        m_act  [3];
    int          m_age  [3];
    logic        m_own  [3];  // 0: port 0, 1: port 1
    logic        m_we   [3];
    logic        m_last [3];
    logic [31:0] m_addr [3];
    logic [31:0] m_wd   [3];
    logic [31:0] m_rd   [3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_act[k] = 1'b0;  m_age[k] = 0;   m_own[k] = 1'b0; m_we[k] = 1'b0;
                m_last[k] = 1'b1; m_addr[k] = '0; m_wd[k] = '0;    m_rd[k] = '0;
            end else if (m_act[k]) begin
                m_age[k]++;
                if (m_age[k] == wait_of(k) && !m_we[k]) m_rd[k] = mem_rdata;
                if (m_age[k] == wait_of(k) + 1) m_act[k] = 1'b0;
            end else if (req0 || req1) begin
                m_own[k]  = (req0 && req1) ? !m_last[k] : req1;
                m_last[k] = m_own[k];
                m_act[k]  = 1'b1;
                m_age[k]  = 0;
                m_we[k]   = m_own[k] ? we1 : we0;
                m_addr[k] = m_own[k] ? addr1 : addr0;
                m_wd[k]   = m_own[k] ? wdata1 : wdata0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [1:0] eg;
            logic       ea0, ea1, ewe;
            eg  = m_act[k] ? (m_own[k] ? 2'b10 : 2'b01) : 2'b00;
            ea0 = m_act[k] && (m_age[k] == wait_of(k)) && !m_own[k];
            ea1 = m_act[k] && (m_age[k] == wait_of(k)) && m_own[k];
            ewe = m_act[k] && m_we[k] && (m_age[k] == wait_of(k) - 1);
            chk($sformatf("m%0d.grant", k), 64'(grant_a[k]), 64'(eg));
            chk($sformatf("m%0d.busy", k), 64'(busy_a[k]), 64'(m_act[k]));
            chk($sformatf("m%0d.ack0", k), 64'(ack0_a[k]), 64'(ea0));
            chk($sformatf("m%0d.ack1", k), 64'(ack1_a[k]), 64'(ea1));
            chk($sformatf("m%0d.mem_we", k), 64'(mwe_a[k]), 64'(ewe));
            chk($sformatf("m%0d.mem_addr", k), 64'(maddr_a[k]), 64'(m_addr[k]));
            if (m_act[k]) chk($sformatf("m%0d.mem_wdata", k), 64'(mwd_a[k]), 64'(m_wd[k]));
            if ((ea0 || ea1) && !m_we[k])
                chk($sformatf("m%0d.rdata", k), 64'(rdata_a[k]), 64'(m_rd[k]));
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) check_all();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1, mrd;
        logic [1:0]  g;
        logic        bz, k0, k1, mwe;
        logic [31:0] maddr, mwd, rd;
        logic        rdchk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r0, r1, w0, w1,
                                input logic [31:0] a0, a1, d0, d1, mrd,
                                input logic [1:0] g, input logic bz, k0, k1, mwe,
                                input logic [31:0] maddr, mwd, rd, input logic rdchk);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.mrd = mrd;
        v.g = g; v.bz = bz; v.k0 = k0; v.k1 = k1; v.mwe = mwe;
        v.maddr = maddr; v.mwd = mwd; v.rd = rd; v.rdchk = rdchk;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
        addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1; mem_rdata = v.mrd;
    endtask

    task automatic set_idle();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    endtask

    int   gs [3];
    int   ak [3];
    logic bad [3];
    logic seen [3];

    initial begin
        reset = 1'b0;
        set_idle();
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst.grant", 64'(grant_a[0]), 64'(2'b00));
        chk("rst.rdata", 64'(rdata_a[0]), 64'(0));
        chk("rst.mem_wdata", 64'(mwd_a[0]), 64'(0));
        reset = 1'b1;

        // Tie held from reset: port 0 first, then strict alternation, 4 cycles per access.
        for (int i = 0; i < 16; i++) begin
            int   ph;
            logic p;
            ph = i % 4;
            p  = ((i / 4) % 2) == 1;
            tbl.push_back(mk(1, 1, 0, 0, 32'h100, 32'h200, 0, 0, 32'h1111_1111,
                             (ph == 3) ? 2'b00 : (p ? 2'b10 : 2'b01), ph != 3,
                             (ph == 2) && !p, (ph == 2) && p, 0,
                             p ? 32'h200 : 32'h100, 0, 32'h1111_1111, 1));
        end
        // Single read on port 0: ack in the third cycle after the grant edge.
        tbl.push_back(mk(1, 0, 0, 0, 32'h10, 0, 0, 0, 32'hDEAD_BEEF, 2'b01, 1, 0, 0, 0,
                         32'h10, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h10, 0, 0, 0, 32'hDEAD_BEEF, 2'b01, 1, 0, 0, 0,
                         32'h10, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h10, 0, 0, 0, 32'hDEAD_BEEF, 2'b01, 1, 1, 0, 0,
                         32'h10, 0, 32'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h10, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,
                         32'h10, 0, 0, 0));
        // Single write on port 1: one strobe, ack one cycle later.
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'h20, 0, 32'h5A5A_5A5A, 0, 2'b10, 1, 0, 0, 0,
                         32'h20, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'h20, 0, 32'h5A5A_5A5A, 0, 2'b10, 1, 0, 0, 1,
                         32'h20, 32'h5A5A_5A5A, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'h20, 0, 32'h5A5A_5A5A, 0, 2'b10, 1, 0, 1, 0,
                         32'h20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h20, 0, 0, 0, 2'b00, 0, 0, 0, 0,
                         32'h20, 0, 0, 0));
        // Operands change after grant: latched address and data are kept.
        tbl.push_back(mk(1, 0, 1, 0, 32'h10, 0, 32'hCAFE_F00D, 0, 0, 2'b01, 1, 0, 0, 0,
                         32'h10, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h99, 0, 32'h1234_5678, 0, 0, 2'b01, 1, 0, 0, 1,
                         32'h10, 32'hCAFE_F00D, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h99, 0, 32'h1234_5678, 0, 0, 2'b01, 1, 1, 0, 0,
                         32'h10, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h99, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0,
                         32'h10, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d.grant", i), 64'(grant_a[0]), 64'(tbl[i].g));
            chk($sformatf("v%0d.busy", i), 64'(busy_a[0]), 64'(tbl[i].bz));
            chk($sformatf("v%0d.ack0", i), 64'(ack0_a[0]), 64'(tbl[i].k0));
            chk($sformatf("v%0d.ack1", i), 64'(ack1_a[0]), 64'(tbl[i].k1));
            chk($sformatf("v%0d.mem_we", i), 64'(mwe_a[0]), 64'(tbl[i].mwe));
            chk($sformatf("v%0d.mem_addr", i), 64'(maddr_a[0]), 64'(tbl[i].maddr));
            if (tbl[i].mwe) chk($sformatf("v%0d.mem_wdata", i), 64'(mwd_a[0]), 64'(tbl[i].mwd));
            if (tbl[i].rdchk && (tbl[i].k0 || tbl[i].k1))
                chk($sformatf("v%0d.rdata", i), 64'(rdata_a[0]), 64'(tbl[i].rd));
        end
        set_idle();
        repeat (20) @(negedge clk);

        // Reset on the first access cycle of a write aborts it cleanly.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h77;
        @(posedge clk);
        @(negedge clk);
        chk("abort.granted", 64'(grant_a[0]), 64'(2'b10));
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort%0d.grant", k), 64'(grant_a[k]), 64'(2'b00));
            chk($sformatf("abort%0d.busy", k), 64'(busy_a[k]), 64'(0));
            chk($sformatf("abort%0d.acks", k), 64'({ack0_a[k], ack1_a[k]}), 64'(0));
            chk($sformatf("abort%0d.mem_we", k), 64'(mwe_a[k]), 64'(0));
            chk($sformatf("abort%0d.mem_addr", k), 64'(maddr_a[k]), 64'(0));
            chk($sformatf("abort%0d.mem_wdata", k), 64'(mwd_a[k]), 64'(0));
        end
        repeat (2) @(negedge clk);
        set_idle();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) seen[k] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (ack0_a[k] || ack1_a[k] || mwe_a[k]) seen[k] = 1'b1;
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("abort%0d.no_late_pulse", k), 64'(seen[k]), 64'(0));

        // Latency sweep: ack lands in cycle W+1 counting the first granted cycle as 1.
        for (int k = 0; k < 3; k++) begin gs[k] = -1; ak[k] = -1; bad[k] = 1'b0; end
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (gs[k] < 0 && grant_a[k] != 2'b00) gs[k] = c;
                if (gs[k] >= 0 && ak[k] < 0) begin
                    if (!busy_a[k]) bad[k] = 1'b1;
                    if (ack0_a[k]) ak[k] = c;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lat%0d.cycles", k), 64'((ak[k] < 0) ? -1 : ak[k] - gs[k] + 1),
                64'(wait_of(k) + 1));
            chk($sformatf("lat%0d.busy_held", k), 64'(bad[k]), 64'(0));
        end
        set_idle();
        repeat (20) @(negedge clk);

        // Random traffic, judged by the model alone.
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 9) < 6);
            req1 = ($urandom_range(0, 9) < 6);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = $urandom; addr1 = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
            mem_rdata = $urandom;
            @(negedge clk);
        end
        set_idle();
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
